// File: rtl/traffic_light_pkg.sv
// Shared light-state encodings for the controller and the colour LED driver.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    YELLOW = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2
  } light_e;

  function automatic light_e next_light(input light_e s);
    case (s)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running 1-second prescaler; tick is registered and high while cnt sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (cnt == TOP) begin
      // A freeze landing on TOP dropped the pulse unconsumed; re-issue it before wrapping.
      if (tick) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else begin
        tick <= 1'b1;
      end
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= (cnt + 1'b1 == TOP);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// RED -> GREEN -> YELLOW controller with per-second countdown and pedestrian green shortening.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV      = 100000000,
  parameter int GREEN_SEC     = 10,
  parameter int YELLOW_SEC    = 3,
  parameter int RED_SEC       = 8,
  parameter int PED_GREEN_SEC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic [1:0] state,
  output logic [3:0] sec_left,
  output logic       ped_pending,
  output logic       tick
);

  localparam logic [3:0] GREEN_T = 4'(GREEN_SEC);
  localparam logic [3:0] YEL_T   = 4'(YELLOW_SEC);
  localparam logic [3:0] RED_T   = 4'(RED_SEC);
  localparam logic [3:0] PED_T   = 4'(PED_GREEN_SEC);

  light_e     state_q, state_d;
  logic [3:0] sec_q, sec_d;
  logic       ped_q, ped_d;
  logic       tick_i;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick_i)
  );

  function automatic logic [3:0] dur(input light_e s);
    case (s)
      GREEN:   return GREEN_T;
      YELLOW:  return YEL_T;
      default: return RED_T;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    ped_d   = ped_q | ped_req;
    case (state_q)
      YELLOW, RED, GREEN: begin
        if (en && tick_i) begin
          if (sec_q > 4'd1) begin
            sec_d = sec_q - 4'd1;
          end else begin
            state_d = next_light(state_q);
            sec_d   = dur(state_d);
          end
        end
        if (state_d == YELLOW && state_q != YELLOW) ped_d = 1'b0;
        // Clamp after any decrement/load so entry and mid-green requests share one path.
        if (en && state_d == GREEN && ped_d && sec_d > PED_T) sec_d = PED_T;
      end
      default: begin
        state_d = RED;
        sec_d   = RED_T;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RED;
      sec_q   <= RED_T;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ped_q   <= ped_d;
    end
  end

  assign state       = state_q;
  assign sec_left    = sec_q;
  assign ped_pending = ped_q;
  assign tick        = tick_i;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl with a small per-edge reference model.
module tb_traffic_light_ctrl;
  import traffic_light_pkg::*;

  localparam int TD = 4, GS = 5, YS = 2, RS = 3, PS = 2;

  logic       clk = 1'b0;
  logic       rst, en, ped_req;
  logic [1:0] state;
  logic [3:0] sec_left;
  logic       ped_pending, tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .TICK_DIV(TD), .GREEN_SEC(GS), .YELLOW_SEC(YS), .RED_SEC(RS), .PED_GREEN_SEC(PS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
    .state(state), .sec_left(sec_left), .ped_pending(ped_pending), .tick(tick)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] sec;
    logic       ped;
    logic       tk;
  } exp_t;

  exp_t sb[$];

  logic [1:0] m_st;
  int         m_sec;
  logic       m_ped;
  int         m_p;
  logic       m_tick;

  function automatic int dur_of(input logic [1:0] s);
    if (s == 2'd2) return GS;
    if (s == 2'd0) return YS;
    return RS;
  endfunction

  task automatic model_reset();
    m_st = 2'd1; m_sec = RS; m_ped = 1'b0; m_p = 0; m_tick = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge(input logic e, input logic pr);
    logic [1:0] n_st;
    int         n_sec;
    logic       n_ped;
    n_st = m_st; n_sec = m_sec;
    if (m_st == 2'd3) begin
      n_st = 2'd1; n_sec = RS;
    end else if (e && m_tick) begin
      if (m_sec > 1) n_sec = m_sec - 1;
      else begin
        n_st  = (m_st == 2'd1) ? 2'd2 : (m_st == 2'd2) ? 2'd0 : 2'd1;
        n_sec = dur_of(n_st);
      end
    end
    n_ped = (m_ped | pr) && !(n_st == 2'd0 && m_st != 2'd0);
    if (e && n_st == 2'd2 && n_ped && n_sec > PS) n_sec = PS;
    if (e) m_p = (m_p == TD - 1) ? 0 : m_p + 1;
    m_tick = e && (m_p == TD - 1);
    m_st = n_st; m_sec = n_sec; m_ped = n_ped;
  endtask

  // One clock: model predicts at the edge, DUT is compared at the following negedge.
  task automatic step();
    exp_t e, g;
    @(posedge clk);
    model_edge(en, ped_req);
    e.st = m_st; e.sec = 4'(m_sec); e.ped = m_ped; e.tk = m_tick;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    g = {state, sec_left, ped_pending, tick};
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL scoreboard t=%0t: got st=%0d sec=%0d ped=%0b tick=%0b, want st=%0d sec=%0d ped=%0b tick=%0b",
               $time, g.st, g.sec, g.ped, g.tk, e.st, e.sec, e.ped, e.tk);
    end
  endtask

  task automatic run_until(input logic [1:0] s, output int n);
    n = 0;
    while (state !== s && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL timeout waiting for state %0d, stuck at %0d", s, state);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; ped_req = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (state !== 2'd1 || sec_left !== 4'd3 || ped_pending !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got st=%0d sec=%0d ped=%0b tick=%0b, want 1/3/0/0",
               state, sec_left, ped_pending, tick);
    end
  endtask

  task automatic test_free_run();
    int n;
    do_reset();
    run_until(2'd2, n);
    total++; if (n != 12) begin bad++; $display("FAIL red_len: got %0d want 12", n); end
    run_until(2'd0, n);
    total++; if (n != 20) begin bad++; $display("FAIL green_len: got %0d want 20", n); end
    run_until(2'd1, n);
    total++; if (n != 8) begin bad++; $display("FAIL yellow_len: got %0d want 8", n); end
    n = 0;
    while (tick !== 1'b1 && n < 20) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 20);
    total++; if (n != 4) begin bad++; $display("FAIL tick_period: got %0d want 4", n); end
  endtask

  task automatic test_ped_green();
    int n;
    do_reset();
    run_until(2'd2, n);
    total++; if (sec_left !== 4'd5) begin bad++; $display("FAIL green_entry_sec: got %0d want 5", sec_left); end
    ped_req = 1'b1; step(); ped_req = 1'b0;
    total++;
    if (sec_left !== 4'd2 || ped_pending !== 1'b1) begin
      bad++; $display("FAIL ped_clamp: got sec=%0d ped=%0b want sec=2 ped=1", sec_left, ped_pending);
    end
    run_until(2'd0, n);
    total++; if (n + 1 != 8) begin bad++; $display("FAIL ped_green_len: got %0d want 8", n + 1); end
    total++; if (ped_pending !== 1'b0) begin bad++; $display("FAIL ped_clear_yellow: got %0b want 0", ped_pending); end
  endtask

  task automatic test_ped_red();
    int n;
    do_reset();
    step(); step();
    ped_req = 1'b1; step(); ped_req = 1'b0;
    total++; if (ped_pending !== 1'b1) begin bad++; $display("FAIL ped_latch_red: got %0b want 1", ped_pending); end
    run_until(2'd2, n);
    total++; if (sec_left !== 4'd2) begin bad++; $display("FAIL ped_entry_sec: got %0d want 2", sec_left); end
    run_until(2'd0, n);
    total++; if (n != 8) begin bad++; $display("FAIL ped_entry_green_len: got %0d want 8", n); end
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    run_until(2'd2, n);
    step();
    en = 1'b0;
    repeat (10) begin
      step();
      total++;
      if (state !== 2'd2 || sec_left !== 4'd5 || tick !== 1'b0 || int'(dut.u_tick_gen.cnt) != 1) begin
        bad++;
        $display("FAIL freeze: got st=%0d sec=%0d tick=%0b cnt=%0d want 2/5/0/1",
                 state, sec_left, tick, dut.u_tick_gen.cnt);
      end
    end
    en = 1'b1;
    run_until(2'd0, n);
    total++; if (n != 19) begin bad++; $display("FAIL resume_green_len: got %0d want 19", n); end
  endtask

  task automatic test_rst_yellow();
    int n;
    do_reset();
    run_until(2'd0, n);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (state !== 2'd1 || sec_left !== 4'd3 || ped_pending !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got st=%0d sec=%0d ped=%0b tick=%0b want 1/3/0/0",
               state, sec_left, ped_pending, tick);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_until(2'd2, n);
    total++; if (n != 12) begin bad++; $display("FAIL post_reset_red_len: got %0d want 12", n); end
  endtask

  task automatic test_illegal();
    do_reset();
    step(); step();
    en = 1'b0;
    force dut.state_q = light_e'(2'd3);
    #1 release dut.state_q;
    m_st = 2'd3;
    step();
    total++;
    if (state !== 2'd1 || sec_left !== 4'd3) begin
      bad++; $display("FAIL illegal_recover: got st=%0d sec=%0d want 1/3", state, sec_left);
    end
    en = 1'b1;
    repeat (6) step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ped_req = 1'b0;
    model_reset();
    test_reset();
    test_free_run();
    test_ped_green();
    test_ped_red();
    test_enable();
    test_rst_yellow();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
